// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone SDRAM arbiter: cycle-type encodings and FSM state.
package wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [0:0] {
    ArbIdle,
    ArbOwned
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after (last_i + 1) mod NUM_MASTERS.
module rr_pick #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          last_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IW-1:0]          idx_o,
  output logic                   valid_o
);

  logic [IW-1:0] k;
  logic          found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = last_i;
    valid_o = 1'b0;
    found   = 1'b0;
    k       = '0;
    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
      k = IW'((int'(last_i) + i) % int'(NUM_MASTERS));
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one SDRAM controller port, grant held for a whole
// cycle (cyc), with a per-grant watchdog that converts a stalled slave into a bus error.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SW = DW / 8;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  logic [AW-1:0] o_adr;
  logic [DW-1:0] o_dat;
  logic [SW-1:0] o_sel;
  logic          o_we, o_cyc, o_stb;
  logic [2:0]    o_cti;
  logic [1:0]    o_bte;

  logic owned, slv_resp, fire;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_rr_pick (
    .req_i   (wbm_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // last_q doubles as the owner index while OWNED.
  always_comb begin
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    o_we  = 1'b0;
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_cti = '0;
    o_bte = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (IW'(k) == last_q) begin
        o_adr = wbm_adr_i[k*AW +: AW];
        o_dat = wbm_dat_i[k*DW +: DW];
        o_sel = wbm_sel_i[k*SW +: SW];
        o_we  = wbm_we_i[k];
        o_cyc = wbm_cyc_i[k];
        o_stb = wbm_stb_i[k];
        o_cti = wbm_cti_i[k*3 +: 3];
        o_bte = wbm_bte_i[k*2 +: 2];
      end
    end
  end

  assign owned    = (state_q == ArbOwned);
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A slave response in the expiry cycle takes precedence over the watchdog.
  assign fire     = owned & o_cyc & o_stb & ~slv_resp & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wbm_dat_o = wbs_dat_i;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    timeout_o = 1'b0;
    if (owned) begin
      wbs_adr_o = o_adr;
      wbs_dat_o = o_dat;
      wbs_sel_o = o_sel;
      wbs_we_o  = o_we;
      wbs_cyc_o = o_cyc & ~fire;
      wbs_stb_o = o_stb & ~fire;
      wbs_cti_o = o_cti;
      wbs_bte_o = o_bte;
      wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
      wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | fire}};
      wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
      timeout_o = fire;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ArbIdle: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d = ArbOwned;
          grant_d = pick_gnt;
          last_d  = pick_idx;
        end
      end
      ArbOwned: begin
        if (!o_cyc) begin
          state_d = ArbIdle;
          grant_d = '0;
          cnt_d   = '0;
        end else if (slv_resp || !o_stb || fire) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ArbIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ArbIdle;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed self-checking bench for wb_sdram_arbiter (4 masters, 16-cycle watchdog).
module tb_wb_sdram_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [127:0] m_adr;
  logic [127:0] m_dat;
  logic [15:0]  m_sel;
  logic [3:0]   m_we, m_cyc, m_stb;
  logic [11:0]  m_cti;
  logic [7:0]   m_bte;
  logic [31:0]  m_dat_o;
  logic [3:0]   m_ack, m_err, m_rty;
  logic [31:0]  s_adr, s_dat_o, s_dat_i;
  logic [3:0]   s_sel;
  logic         s_we, s_cyc, s_stb;
  logic [2:0]   s_cti;
  logic [1:0]   s_bte;
  logic         s_ack, s_err, s_rty;
  logic [3:0]   grant;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int order[6] = '{0, 1, 3, 0, 1, 3};
  int idx;

  wb_sdram_arbiter #(
    .NUM_MASTERS    (N),
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbm_adr_i  (m_adr),
    .wbm_dat_i  (m_dat),
    .wbm_sel_i  (m_sel),
    .wbm_we_i   (m_we),
    .wbm_cyc_i  (m_cyc),
    .wbm_stb_i  (m_stb),
    .wbm_cti_i  (m_cti),
    .wbm_bte_i  (m_bte),
    .wbm_dat_o  (m_dat_o),
    .wbm_ack_o  (m_ack),
    .wbm_err_o  (m_err),
    .wbm_rty_o  (m_rty),
    .wbs_adr_o  (s_adr),
    .wbs_dat_o  (s_dat_o),
    .wbs_sel_o  (s_sel),
    .wbs_we_o   (s_we),
    .wbs_cyc_o  (s_cyc),
    .wbs_stb_o  (s_stb),
    .wbs_cti_o  (s_cti),
    .wbs_bte_o  (s_bte),
    .wbs_dat_i  (s_dat_i),
    .wbs_ack_i  (s_ack),
    .wbs_err_i  (s_err),
    .wbs_rty_i  (s_rty),
    .grant_o    (grant),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL tb_time_limit: observed no finish, expected finish before 200000");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int k, input logic on, input logic [31:0] adr, input logic [2:0] cti);
    m_cyc[k]           = on;
    m_stb[k]           = on;
    m_adr[k*32 +: 32]  = adr;
    m_cti[k*3 +: 3]    = cti;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_wbs_cyc", s_cyc, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // Single classic read from master 2.
    req(2, 1'b1, 32'h0000_0100, 3'b000);
    #1;
    chk("t1_lat_grant", grant, 0);
    chk("t1_lat_cyc", s_cyc, 0);
    step();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_wbs_cyc", s_cyc, 1);
    chk("t1_wbs_adr", s_adr, 32'h0000_0100);
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", m_ack, 4'b0100);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    step();
    s_ack = 1'b0; req(2, 1'b0, 32'h0, 3'b000);
    #1;
    chk("t1_hold", grant, 4'b0100);
    chk("t1_ack_clr", m_ack, 0);
    step();
    chk("t1_idle", grant, 0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Round robin among 0, 1, 3 with single-beat cycles.
    req(0, 1'b1, 32'h10, 3'b000);
    req(1, 1'b1, 32'h14, 3'b000);
    req(3, 1'b1, 32'h1C, 3'b000);
    step();
    for (int i = 0; i < 6; i++) begin
      idx = order[i];
      chk($sformatf("t2_grant%0d", i), grant, 64'(4'b0001 << idx));
      s_ack = 1'b1;
      #1;
      chk($sformatf("t2_ack%0d", i), m_ack, 64'(4'b0001 << idx));
      step();
      s_ack = 1'b0;
      m_cyc[idx] = 1'b0; m_stb[idx] = 1'b0;
      step();
      chk($sformatf("t2_gap%0d", i), grant, 0);
      if (i < 5) begin
        m_cyc[idx] = 1'b1; m_stb[idx] = 1'b1;
        step();
      end
    end
    m_cyc = '0; m_stb = '0;
    step();

    // Master 1 four-beat incrementing burst while master 0 waits.
    req(1, 1'b1, 32'h200, 3'b010);
    step();
    chk("t3_grant", grant, 4'b0010);
    req(0, 1'b1, 32'h300, 3'b000);
    for (int b = 0; b < 4; b++) begin
      m_cti[3 +: 3]  = (b == 3) ? 3'b111 : 3'b010;
      m_adr[32 +: 32] = 32'h200 + 32'(4 * b);
      s_ack = 1'b1;
      #1;
      chk($sformatf("t3_grant_b%0d", b), grant, 4'b0010);
      chk($sformatf("t3_ack_b%0d", b), m_ack, 4'b0010);
      chk($sformatf("t3_cti_b%0d", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
      step();
    end
    s_ack = 1'b0;
    #1;
    chk("t3_eob_hold", grant, 4'b0010);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    chk("t3_gap", grant, 0);
    chk("t3_gap_cyc", s_cyc, 0);
    step();
    chk("t3_m0_grant", grant, 4'b0001);
    chk("t3_m0_adr", s_adr, 32'h300);

    // Watchdog: slave never answers master 0.
    req(1, 1'b1, 32'h400, 3'b000);
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("t4_stall_to%0d", c), timeout, 0);
      chk($sformatf("t4_stall_cyc%0d", c), s_cyc, 1);
      step();
    end
    chk("t4_fire_to", timeout, 1);
    chk("t4_fire_err", m_err, 4'b0001);
    chk("t4_fire_cyc", s_cyc, 0);
    chk("t4_fire_stb", s_stb, 0);
    step();
    chk("t4_after_to", timeout, 0);
    chk("t4_after_err", m_err, 0);
    chk("t4_after_grant", grant, 4'b0001);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    chk("t4_gap", grant, 0);
    step();
    chk("t4_m1_grant", grant, 4'b0010);

    // Ack lands in the exact expiry cycle.
    for (int c = 0; c < 15; c++) step();
    s_ack = 1'b1;
    #1;
    chk("t5_ack", m_ack, 4'b0010);
    chk("t5_err", m_err, 0);
    chk("t5_to", timeout, 0);
    chk("t5_cyc", s_cyc, 1);
    step();
    s_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    chk("t5_to_next", timeout, 0);
    step();
    chk("t5_gap", grant, 0);

    // Reset mid-burst of master 3; master 0 then wins.
    req(3, 1'b1, 32'h500, 3'b010);
    step();
    chk("t6_grant", grant, 4'b1000);
    s_ack = 1'b1;
    step();
    req(0, 1'b1, 32'h600, 3'b000);
    rst_n = 1'b0;
    step();
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_cyc", s_cyc, 0);
    chk("t6_rst_stb", s_stb, 0);
    chk("t6_rst_ack", m_ack, 0);
    chk("t6_rst_to", timeout, 0);
    rst_n = 1'b1;
    s_ack = 1'b0;
    step();
    chk("t6_m0_first", grant, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
